cpu_run_ctrl: RTL

//  Run/halt/single-step sequencer for the MIPS core on the board.

---
 rtl/cpu_run_ctrl_if.sv | 22 ++
 rtl/cpu_run_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the board-level button logic and the run controller.
// The master side drives buttons, halt request and speed; the slave side returns the enable and status.
interface cpu_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [1:0]       btn;
    logic             halt_req;
    logic [1:0]       speed;
    logic             cpu_en;
    logic             running;
    logic [CNT_W-1:0] step_cnt;

    modport master (
        output btn, halt_req, speed,
        input  cpu_en, running, step_cnt
    );

    modport slave (
        input  btn, halt_req, speed,
        output cpu_en, running, step_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer producing a 1-cycle CPU clock-enable,
// either per step request or periodically at a selectable rate while running.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | halted; waits for run, step or counter-clear gesture
// RUN     | free-running; enables issued by the rate divider
// STEP    | one enable issued, then back to IDLE
module cpu_run_ctrl #(
    parameter int CNT_W     = 32,
    parameter int DIV_W     = 26,
    parameter int RATE_SLOW = 50_000_000,
    parameter int RATE_MID  = 5_000_000,
    parameter int RATE_FAST = 500_000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    cpu_run_ctrl_if.slave io_ctl
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    localparam logic [DIV_W-1:0] L_TC_SLOW = DIV_W'(RATE_SLOW - 1);
    localparam logic [DIV_W-1:0] L_TC_MID  = DIV_W'(RATE_MID - 1);
    localparam logic [DIV_W-1:0] L_TC_FAST = DIV_W'(RATE_FAST - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_div_tc;
    logic [1:0]       r_speed_sh;
    logic             r_cpu_en;
    logic             w_en_nxt;
    logic             r_running;
    logic [CNT_W-1:0] r_step_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_comb begin
        case (io_ctl.speed)
            2'd0:    w_div_tc = L_TC_SLOW;
            2'd1:    w_div_tc = L_TC_MID;
            default: w_div_tc = L_TC_FAST;
        endcase
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_div_nxt   = '0;
        w_en_nxt    = 1'b0;
        w_cnt_nxt   = r_step_cnt;
        case (r_state)
            ST_IDLE: begin
                if (io_ctl.btn == 2'b11) begin
                    w_cnt_nxt = '0;
                end else if (io_ctl.btn == 2'b01 && !io_ctl.halt_req) begin
                    w_state_nxt = ST_RUN;
                end else if (io_ctl.btn == 2'b10) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                w_en_nxt = 1'b1;
            end
            ST_RUN: begin
                // Halt request wins over a simultaneous run/stop press.
                if (io_ctl.halt_req || io_ctl.btn[0]) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
                if (io_ctl.speed == 2'd3) begin
                    w_en_nxt = 1'b1;
                end else if (io_ctl.speed != r_speed_sh) begin
                    w_div_nxt = '0;
                end else if (r_div == w_div_tc) begin
                    w_en_nxt = 1'b1;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_en_nxt) begin
            w_cnt_nxt = r_step_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_speed_sh <= 2'd0;
            r_cpu_en   <= 1'b0;
            r_running  <= 1'b0;
            r_step_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_speed_sh <= io_ctl.speed;
            r_cpu_en   <= w_en_nxt;
            r_running  <= (w_state_nxt == ST_RUN);
            r_step_cnt <= w_cnt_nxt;
        end
    end

    assign io_ctl.cpu_en   = r_cpu_en;
    assign io_ctl.running  = r_running;
    assign io_ctl.step_cnt = r_step_cnt;

endmodule
